// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the PIC acknowledge path: level sizing, spurious level,
// handshake state encoding and small ISR bit helpers.
package interrupt_ack_sequencer_pkg;

  localparam int NUM_LEVELS = 8;
  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } ackState_t;

  // Non-specific EOI: drop the highest-priority (lowest-index) in-service bit.
  function automatic logic [NUM_LEVELS-1:0] clearLowest(input logic [NUM_LEVELS-1:0] bits);
    return bits & (bits - NUM_LEVELS'(1));
  endfunction

  function automatic logic [NUM_LEVELS-1:0] levelMask(input logic [LEVEL_W-1:0] level);
    return NUM_LEVELS'(1) << level;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_select.sv
// Fixed-priority find-first over pending requests; any in-service bit at or above
// a level's priority blocks that level and everything below it.
module interrupt_ack_sequencer_priority_select
  import interrupt_ack_sequencer_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] requests,
  input  logic [NUM_LEVELS-1:0] isr,
  output logic                  valid,
  output logic [LEVEL_W-1:0]    level
);

  logic blocked;

  always_comb begin
    valid   = 1'b0;
    level   = '0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      blocked = blocked | isr[i];
      if (!valid && !blocked && requests[i]) begin
        valid = 1'b1;
        level = LEVEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// CPU side of the PIC: raises INT, runs the two-pulse INTA handshake, drives the
// vector, owns the ISR and reports the serviced level back to the IRR.
module interrupt_ack_sequencer
  import interrupt_ack_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] risedBits,
  input  logic [4:0]            vectorBase,
  input  logic                  autoEOI,
  input  logic                  eoi,
  input  logic                  INTA_n,
  output logic                  INT,
  output logic [7:0]            dataBus,
  output logic                  dataBusEn,
  output logic                  readPriority,
  output logic [LEVEL_W-1:0]    resetIRR,
  output logic [NUM_LEVELS-1:0] inServiceReg
);

  ackState_t state, stateNext;

  logic                  intaQ, intaPrev;
  logic                  intaFall, intaRise;
  logic                  eligValid;
  logic [LEVEL_W-1:0]    eligLevel;
  logic [LEVEL_W-1:0]    levelQ;
  logic                  spuriousQ;
  logic [NUM_LEVELS-1:0] isrQ, isrNext;
  logic [NUM_LEVELS-1:0] setMask, clrMask;
  logic                  latchLevel;

  interrupt_ack_sequencer_priority_select uPrioritySelect (
    .requests (risedBits),
    .isr      (isrQ),
    .valid    (eligValid),
    .level    (eligLevel)
  );

  // Edges are taken between the sampled value and the one before it, so each
  // INTA transition is acted on one cycle after it is first registered.
  assign intaFall = intaPrev & ~intaQ;
  assign intaRise = ~intaPrev & intaQ;

  always_comb begin
    stateNext  = state;
    latchLevel = 1'b0;
    setMask    = '0;
    clrMask    = '0;
    case (state)
      IDLE: begin
        if (eligValid) stateNext = REQ;
      end
      REQ: begin
        if (intaFall) begin
          latchLevel = 1'b1;
          stateNext  = ACK1;
          if (eligValid) setMask = levelMask(eligLevel);
        end
      end
      ACK1: begin
        if (intaRise) stateNext = WAIT2;
      end
      WAIT2: begin
        if (intaFall) stateNext = ACK2;
      end
      ACK2: begin
        if (intaRise) begin
          stateNext = IDLE;
          if (autoEOI && !spuriousQ) clrMask = levelMask(levelQ);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // EOI sees the ISR before this cycle's set, so a freshly accepted level survives.
  always_comb begin
    isrNext = ((eoi ? clearLowest(isrQ) : isrQ) | setMask) & ~clrMask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      intaQ        <= 1'b1;
      intaPrev     <= 1'b1;
      isrQ         <= '0;
      levelQ       <= '0;
      spuriousQ    <= 1'b0;
      readPriority <= 1'b0;
      resetIRR     <= '0;
    end else begin
      state        <= stateNext;
      intaQ        <= INTA_n;
      intaPrev     <= intaQ;
      isrQ         <= isrNext;
      readPriority <= latchLevel & eligValid;
      if (latchLevel) begin
        levelQ    <= eligValid ? eligLevel : SPURIOUS_LEVEL;
        spuriousQ <= ~eligValid;
        if (eligValid) resetIRR <= eligLevel;
      end
    end
  end

  assign INT          = (state == REQ);
  assign dataBusEn    = (state == ACK2);
  assign dataBus      = dataBusEn ? {vectorBase, levelQ} : 8'h00;
  assign inServiceReg = isrQ;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed per-cycle vector bench for interrupt_ack_sequencer, plus hand-built
// sequences for asynchronous reset mid-handshake and EOI colliding with an ISR set.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] risedBits;
  logic [4:0] vectorBase;
  logic       autoEOI;
  logic       eoi;
  logic       INTA_n;
  logic       INT;
  logic [7:0] dataBus;
  logic       dataBusEn;
  logic       readPriority;
  logic [2:0] resetIRR;
  logic [7:0] inServiceReg;

  int checks = 0;
  int errors = 0;

  interrupt_ack_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .risedBits    (risedBits),
    .vectorBase   (vectorBase),
    .autoEOI      (autoEOI),
    .eoi          (eoi),
    .INTA_n       (INTA_n),
    .INT          (INT),
    .dataBus      (dataBus),
    .dataBusEn    (dataBusEn),
    .readPriority (readPriority),
    .resetIRR     (resetIRR),
    .inServiceReg (inServiceReg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rb;
    logic       aeoi;
    logic       eoi;
    logic       inta;
    logic       expInt;
    logic       expEn;
    logic [7:0] expBus;
    logic       expRp;
    logic [2:0] expRirr;
    logic [7:0] expIsr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] rb, input logic aeoi, input logic e,
                              input logic inta, input logic xInt, input logic xEn,
                              input logic [7:0] xBus, input logic xRp,
                              input logic [2:0] xRirr, input logic [7:0] xIsr);
    vec_t v;
    v.rb = rb; v.aeoi = aeoi; v.eoi = e; v.inta = inta;
    v.expInt = xInt; v.expEn = xEn; v.expBus = xBus;
    v.expRp = xRp; v.expRirr = xRirr; v.expIsr = xIsr;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic checkOutputs(input vec_t v, input int row);
    chk("INT", row, {7'd0, INT}, {7'd0, v.expInt});
    chk("dataBusEn", row, {7'd0, dataBusEn}, {7'd0, v.expEn});
    chk("dataBus", row, dataBus, v.expBus);
    chk("readPriority", row, {7'd0, readPriority}, {7'd0, v.expRp});
    if (v.expRp) chk("resetIRR", row, {5'd0, resetIRR}, {5'd0, v.expRirr});
    chk("inServiceReg", row, inServiceReg, v.expIsr);
  endtask

  // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
  task automatic runVec(input vec_t v, input int row);
    risedBits = v.rb;
    autoEOI   = v.aeoi;
    eoi       = v.eoi;
    INTA_n    = v.inta;
    @(posedge clk);
    @(negedge clk);
    checkOutputs(v, row);
  endtask

  initial begin
    vec_t r;
    int   rowId;

    reset      = 1'b1;
    risedBits  = 8'h00;
    vectorBase = 5'h10;
    autoEOI    = 1'b0;
    eoi        = 1'b0;
    INTA_n     = 1'b1;

    // IR3 with AEOI off; ISR stays 08 afterwards.
    vecs.push_back(mk(8'h08,0,0,1, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h08,0,0,0, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h08,0,0,0, 0,0,8'h00,1,3,8'h08));
    vecs.push_back(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,0, 0,1,8'h83,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,0, 0,1,8'h83,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,1, 0,1,8'h83,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h08));
    // Nested IR1 over IR3 in service; IR5 stays blocked; two EOIs unwind.
    vecs.push_back(mk(8'h22,0,0,1, 1,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h22,0,0,0, 1,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h22,0,0,0, 0,0,8'h00,1,1,8'h0A));
    vecs.push_back(mk(8'h20,0,0,0, 0,0,8'h00,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,0,1, 0,0,8'h00,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,0,1, 0,0,8'h00,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,0,0, 0,0,8'h00,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,0,0, 0,1,8'h81,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,0,1, 0,1,8'h81,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,0,1, 0,0,8'h00,0,0,8'h0A));
    vecs.push_back(mk(8'h20,0,1,1, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h00,0,1,1, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00));
    // AEOI: IR3 clears itself, then IR5 re-raises INT straight after.
    vecs.push_back(mk(8'h08,1,0,1, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h08,1,0,0, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h08,1,0,0, 0,0,8'h00,1,3,8'h08));
    vecs.push_back(mk(8'h20,1,0,0, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h20,1,0,1, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h20,1,0,1, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h20,1,0,0, 0,0,8'h00,0,0,8'h08));
    vecs.push_back(mk(8'h20,1,0,0, 0,1,8'h83,0,0,8'h08));
    vecs.push_back(mk(8'h20,1,0,1, 0,1,8'h83,0,0,8'h08));
    vecs.push_back(mk(8'h20,1,0,1, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h20,1,0,1, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h20,1,0,0, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h20,1,0,0, 0,0,8'h00,1,5,8'h20));
    vecs.push_back(mk(8'h00,1,0,1, 0,0,8'h00,0,0,8'h20));
    vecs.push_back(mk(8'h00,1,0,1, 0,0,8'h00,0,0,8'h20));
    vecs.push_back(mk(8'h00,1,0,0, 0,0,8'h00,0,0,8'h20));
    vecs.push_back(mk(8'h00,1,0,0, 0,1,8'h85,0,0,8'h20));
    vecs.push_back(mk(8'h00,1,0,1, 0,1,8'h85,0,0,8'h20));
    vecs.push_back(mk(8'h00,1,0,1, 0,0,8'h00,0,0,8'h00));
    // Request vanishes before the first INTA: spurious vector, no ISR, no readPriority.
    vecs.push_back(mk(8'h08,1,0,1, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,0, 1,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,0, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,1, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,1, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,0, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,0, 0,1,8'h87,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,1, 0,1,8'h87,0,0,8'h00));
    vecs.push_back(mk(8'h00,1,0,1, 0,0,8'h00,0,0,8'h00));
    // INTA pulse while idle is ignored.
    vecs.push_back(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00));
    vecs.push_back(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00));

    repeat (2) @(negedge clk);
    r = mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00);
    checkOutputs(r, 0);
    reset = 1'b0;

    rowId = 1;
    foreach (vecs[i]) begin
      runVec(vecs[i], rowId);
      rowId++;
    end

    // Async reset while the vector is on the bus.
    rowId = 100;
    runVec(mk(8'h08,0,0,1, 1,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h08,0,0,0, 1,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h08,0,0,0, 0,0,8'h00,1,3,8'h08), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h08), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h08), rowId++);
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h08), rowId++);
    runVec(mk(8'h00,0,0,0, 0,1,8'h83,0,0,8'h08), rowId++);
    #2 reset = 1'b1;
    #1 checkOutputs(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00), rowId++);
    @(negedge clk);
    reset = 1'b0;
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h00), rowId++);

    // EOI lands in the same cycle IR1 is set over IR2 in service.
    rowId = 200;
    runVec(mk(8'h04,0,0,1, 1,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h04,0,0,0, 1,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h04,0,0,0, 0,0,8'h00,1,2,8'h04), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h04), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h04), rowId++);
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h04), rowId++);
    runVec(mk(8'h00,0,0,0, 0,1,8'h82,0,0,8'h04), rowId++);
    runVec(mk(8'h00,0,0,1, 0,1,8'h82,0,0,8'h04), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h04), rowId++);
    runVec(mk(8'h02,0,0,1, 1,0,8'h00,0,0,8'h04), rowId++);
    runVec(mk(8'h02,0,0,0, 1,0,8'h00,0,0,8'h04), rowId++);
    runVec(mk(8'h02,0,1,0, 0,0,8'h00,1,1,8'h02), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h02), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h02), rowId++);
    runVec(mk(8'h00,0,0,0, 0,0,8'h00,0,0,8'h02), rowId++);
    runVec(mk(8'h00,0,0,0, 0,1,8'h81,0,0,8'h02), rowId++);
    runVec(mk(8'h00,0,0,1, 0,1,8'h81,0,0,8'h02), rowId++);
    runVec(mk(8'h00,0,0,1, 0,0,8'h00,0,0,8'h02), rowId++);
    runVec(mk(8'h00,0,1,1, 0,0,8'h00,0,0,8'h00), rowId++);
    runVec(mk(8'h00,0,1,1, 0,0,8'h00,0,0,8'h00), rowId++);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
